// File: rtl/frame_pick.sv
// frame_pick: hunts a SYNC0,SYNC0,SYNC1 header, reads a length control word, then
// forwards exactly that many words as a registered, framed pixel stream.
module frame_pick #(
  parameter int              DW      = 16,
  parameter logic [DW-1:0]   SYNC0   = {DW{1'b1}},
  parameter logic [DW-1:0]   SYNC1   = DW'(16'hAAAA),
  parameter int              MAX_PIX = 1024,
  parameter int              LW      = $clog2(MAX_PIX + 1)
) (
  input  logic          CLK,
  input  logic          nRST,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          pix_valid,
  output logic [DW-1:0] pix_data,
  output logic          pix_sof,
  output logic          pix_eof,
  output logic          frame_done,
  output logic          hdr_err,
  output logic [15:0]   frame_cnt
);

  localparam logic [2:0] HUNT   = 3'd0;
  localparam logic [2:0] SYNC_B = 3'd1;
  localparam logic [2:0] SYNC_C = 3'd2;
  localparam logic [2:0] CTRL   = 3'd3;
  localparam logic [2:0] PIXEL  = 3'd4;

  localparam logic [LW-1:0] MAX_LEN = LW'(MAX_PIX);

  logic [2:0]    state_q, state_d;
  logic [LW-1:0] len_q, len_d;
  logic [LW-1:0] idx_q, idx_d;
  logic          pix_valid_q, pix_valid_d;
  logic [DW-1:0] pix_data_q, pix_data_d;
  logic          pix_sof_q, pix_sof_d;
  logic          pix_eof_q, pix_eof_d;
  logic          frame_done_q, frame_done_d;
  logic          hdr_err_q, hdr_err_d;
  logic [15:0]   frame_cnt_q, frame_cnt_d;

  logic [LW-1:0] ctrl_len;
  logic          last_pix;

  // Bits of the control word above the length field are ignored.
  assign ctrl_len = in_data[LW-1:0];
  assign last_pix = (idx_q == len_q - LW'(1));

  always_comb begin
    // NOTE: every next-state value gets a default first so no path leaves a latch.
    state_d      = state_q;
    len_d        = len_q;
    idx_d        = idx_q;
    pix_valid_d  = 1'b0;
    pix_data_d   = '0;
    pix_sof_d    = 1'b0;
    pix_eof_d    = 1'b0;
    frame_done_d = 1'b0;
    hdr_err_d    = 1'b0;
    frame_cnt_d  = frame_cnt_q;

    if (in_valid) begin
      case (state_q)
        HUNT: begin
          if (in_data == SYNC0) state_d = SYNC_B;
        end
        SYNC_B: begin
          state_d = (in_data == SYNC0) ? SYNC_C : HUNT;
        end
        SYNC_C: begin
          if (in_data == SYNC1)      state_d = CTRL;
          else if (in_data != SYNC0) state_d = HUNT;
        end
        CTRL: begin
          if (ctrl_len == '0 || ctrl_len > MAX_LEN) begin
            hdr_err_d = 1'b1;
            state_d   = HUNT;
          end else begin
            len_d   = ctrl_len;
            idx_d   = '0;
            state_d = PIXEL;
          end
        end
        PIXEL: begin
          // Payload is never matched against sync patterns.
          pix_valid_d = 1'b1;
          pix_data_d  = in_data;
          pix_sof_d   = (idx_q == '0);
          if (last_pix) begin
            pix_eof_d    = 1'b1;
            frame_done_d = 1'b1;
            frame_cnt_d  = frame_cnt_q + 16'd1;
            state_d      = HUNT;
          end else begin
            idx_d = idx_q + LW'(1);
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q      <= HUNT;
      len_q        <= '0;
      idx_q        <= '0;
      pix_valid_q  <= 1'b0;
      pix_data_q   <= '0;
      pix_sof_q    <= 1'b0;
      pix_eof_q    <= 1'b0;
      frame_done_q <= 1'b0;
      hdr_err_q    <= 1'b0;
      frame_cnt_q  <= '0;
    end else begin
      // NOTE: non-blocking updates so every register sees pre-edge values.
      state_q      <= state_d;
      len_q        <= len_d;
      idx_q        <= idx_d;
      pix_valid_q  <= pix_valid_d;
      pix_data_q   <= pix_data_d;
      pix_sof_q    <= pix_sof_d;
      pix_eof_q    <= pix_eof_d;
      frame_done_q <= frame_done_d;
      hdr_err_q    <= hdr_err_d;
      frame_cnt_q  <= frame_cnt_d;
    end
  end

  assign pix_valid  = pix_valid_q;
  assign pix_data   = pix_data_q;
  assign pix_sof    = pix_sof_q;
  assign pix_eof    = pix_eof_q;
  assign frame_done = frame_done_q;
  assign hdr_err    = hdr_err_q;
  assign frame_cnt  = frame_cnt_q;

endmodule

// File: doc/frame_pick.md
# frame_pick

Parametrised successor to the fixed 16-pixel sync-word picker. It hunts a `SYNC0, SYNC0, SYNC1` header in a word stream, then reads a control word that carries the frame length. It forwards exactly that many pixel words as a registered, framed pixel stream with start/end markers, error reporting and a frame counter. It sits between the sensor/link word receiver and the pixel processing pipeline.

## Interface
Parameters:
- `DW`, 16, word/pixel width; `DW >= LW` required
- `SYNC0`, `{DW{1'b1}}`, first/second header word
- `SYNC1`, `16'hAAAA` zero-extended/truncated to `DW`, third header word
- `MAX_PIX`, 1024, largest legal frame length
- `LW`, `$clog2(MAX_PIX+1)`, length field width in the control word

Ports:
- `CLK`  in  1  clock
- `nRST`  in  1  reset, asynchronous, active-low
- `in_valid`  in  1  `in_data` is a valid word this cycle
- `in_data`  in  `DW`  input word
- `pix_valid`  out  1  pixel output valid
- `pix_data`  out  `DW`  pixel word; zero when `pix_valid`=0
- `pix_sof`  out  1  first pixel of frame (qualified by `pix_valid`)
- `pix_eof`  out  1  last pixel of frame (qualified by `pix_valid`)
- `frame_done`  out  1  one-cycle pulse, coincident with `pix_eof`
- `hdr_err`  out  1  one-cycle pulse: control word length illegal
- `frame_cnt`  out  16  completed-frame count, wraps `16'hFFFF`->0

## Operation
- States: `HUNT`, `SYNC_B`, `SYNC_C`, `CTRL`, `PIXEL`. The FSM advances only on cycles with `in_valid`=1. With `in_valid`=0, state, counters and pixel index hold.
- `HUNT`: word==`SYNC0` -> `SYNC_B`; else stay.
- `SYNC_B`: word==`SYNC0` -> `SYNC_C`; else -> `HUNT`.
- `SYNC_C`: word==`SYNC1` -> `CTRL`; word==`SYNC0` -> stay (extra sync words tolerated); else -> `HUNT`.
- `CTRL`: `len = in_data[LW-1:0]`; upper bits ignored.
  - `len`==0 or `len`>`MAX_PIX`: pulse `hdr_err` next cycle, -> `HUNT`.
  - Otherwise latch `len` and clear the pixel index -> `PIXEL`.
- `PIXEL`: each valid word is emitted as a pixel and the index is incremented.
  - Index 0 sets `pix_sof`.
  - Index `len-1` sets `pix_eof` and `frame_done`, increments `frame_cnt`, then -> `HUNT`.
  - Pixel words are never compared against sync patterns; a `SYNC0` inside the payload is data.
- Index counter is `LW` bits and never exceeds `len-1`.
- A length-1 frame asserts `pix_sof` and `pix_eof` on the same pixel.

## Timing
- All outputs are registered. A pixel consumed on edge N appears on `pix_valid`/`pix_data` during cycle N+1 for exactly one cycle.
- `hdr_err` appears the cycle after the bad control word is sampled.
- `frame_cnt` updates on the same edge that raises `frame_done`.
- Back-to-back frames: the next header's first `SYNC0` may arrive in the cycle immediately after the last pixel. The minimum gap between the last pixel of one frame and the first pixel of the next is 4 valid words.
- Reset (async assert, any state including mid-frame):
  - State -> `HUNT`.
  - `pix_valid`, `pix_sof`, `pix_eof`, `frame_done`, `hdr_err` = 0; `pix_data` = 0; `frame_cnt` = 0; length and index registers = 0.
- After reset deassertion, the first edge may already sample `SYNC0`.
- A partial frame cut by reset emits no `pix_eof` and does not count.

## Test plan
- Basic frame: `FFFF,FFFF,AAAA,0004,P0..P3`, `in_valid` continuous -> four `pix_valid` cycles starting 1 cycle after P0 is sampled. `pix_sof` on P0, `pix_eof`/`frame_done` on P3, `frame_cnt`=1.
- Gapped input: same frame with `in_valid` low every other cycle -> identical pixel sequence. `pix_valid` is high only the cycle after each valid pixel. `frame_cnt`=1.
- Header robustness:
  - `FFFF,FFFF,FFFF,AAAA,0002,...` -> frame accepted, 2 pixels.
  - `FFFF,1234,FFFF,FFFF,AAAA,0001,P0` -> first attempt dropped, one length-1 frame with `pix_sof`=`pix_eof`=1.
- Bad length: control word 0000, then a control word of `MAX_PIX+1` -> `hdr_err` pulse each time, no `pix_valid`, `frame_cnt` unchanged. A following legal frame parses normally.
- Back-to-back frames, with `FFFF` as payload data: 3 frames of length 16, one containing `FFFF` pixels -> 48 pixels, 3 `frame_done` pulses, `frame_cnt`=3. Payload `FFFF` is passed as data.
- Reset mid-frame: assert `nRST` low after P5 of a 16-pixel frame -> all outputs 0 asynchronously. After release, a new length-3 frame yields exactly 3 pixels and `frame_cnt`=1.
